// File: rtl/if_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_pkg
// Shared stage1 (instruction fetch) definitions for the Jahangir MIPS32
// pipeline: fetch FSM state encoding, PC width and the NOP instruction word.
// No ports; imported by if_fetch_unit.
// ---------------------------------------------------------------------------
package if_fetch_unit_pkg;

   localparam int PC_W = 32;

   // All-zero word is sll $0,$0,0, which the pipeline treats as a NOP.
   localparam logic [PC_W-1:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_VALID = 2'd3
   } fetch_state_e;

   // Redirect targets must be word aligned; the low two bits are dropped.
   function automatic logic [PC_W-1:0] align_target(input logic [PC_W-1:0] t);
      return {t[PC_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch producer for stage1. Owns the PC, issues one
// instruction-memory read at a time (req/gnt/rvalid) and presents the
// fetched PC/instruction pair to the IF/ID register.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   stall_i               IF/ID not accepting; hold presented instruction
//   flush_i               redirect; PC reloads from branch_target_i
//   branch_target_i       redirect address (bits [1:0] forced to 0)
//   imem_req_o/addr_o     read request and address (address = PC)
//   imem_gnt_i            memory accepted the request this cycle
//   imem_rvalid_i/rdata_i read response
//   if_pc_o/if_inst_o     presented PC and instruction
//   if_valid_o            presented pair holds a valid fetched instruction
// ---------------------------------------------------------------------------
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned     PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic [PC_W-1:0] branch_target_i,
   output logic            imem_req_o,
   output logic [PC_W-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [PC_W-1:0] imem_rdata_i,
   output logic [PC_W-1:0] if_pc_o,
   output logic [PC_W-1:0] if_inst_o,
   output logic            if_valid_o
);

   fetch_state_e    state_q;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] inst_q;
   logic            drop_q;
   logic [PC_W-1:0] target;

   assign target = align_target(branch_target_i);

   // Fetch sequencer. drop_q remembers that the read currently in flight was
   // overtaken by a redirect, so its data must be thrown away on arrival.
   // A flush in REQ may move the PC even while the request is pending; the
   // address only changes when the redirect itself is requested, never on
   // its own. Flush outranks stall in VALID so a redirect is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= NOP_INST;
         drop_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_REQ;
            end
            ST_REQ: begin
               if (flush_i) begin
                  pc_q <= target;
               end
               if (imem_gnt_i) begin
                  drop_q  <= flush_i;
                  state_q <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid_i) begin
                  if (drop_q || flush_i) begin
                     drop_q  <= 1'b0;
                     state_q <= ST_REQ;
                     if (flush_i) begin
                        pc_q <= target;
                     end
                  end else begin
                     inst_q  <= imem_rdata_i;
                     state_q <= ST_VALID;
                  end
               end else if (flush_i) begin
                  pc_q   <= target;
                  drop_q <= 1'b1;
               end
            end
            ST_VALID: begin
               if (flush_i) begin
                  pc_q    <= target;
                  state_q <= ST_REQ;
               end else if (!stall_i) begin
                  pc_q    <= pc_q + PC_W'(PC_STEP);
                  state_q <= ST_REQ;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Every output is a direct view of registered state, so nothing here
   // depends combinationally on the memory or IF/ID inputs.
   assign imem_req_o  = (state_q == ST_REQ);
   assign imem_addr_o = pc_q;
   assign if_pc_o     = pc_q;
   assign if_inst_o   = inst_q;
   assign if_valid_o  = (state_q == ST_VALID);

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch producer for stage1 of the Jahangir MIPS32 pipeline. It owns the program counter, issues one instruction-memory read at a time over a req/gnt/rvalid handshake, and presents the fetched PC/instruction pair, with a valid flag, to the IF/ID pipeline register. It honours downstream stall and branch/flush redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
PC_STEP, 4, byte increment between sequential fetches

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
stall_i  in  1  downstream (IF/ID) not accepting; hold presented instruction
flush_i  in  1  redirect request; PC reloads from branch_target_i
branch_target_i  in  32  redirect address; bits [1:0] ignored (forced 0)
imem_req_o  out  1  read request to instruction memory
imem_addr_o  out  32  read address, equals current PC
imem_gnt_i  in  1  memory accepted request this cycle
imem_rvalid_i  in  1  read data valid
imem_rdata_i  in  32  read data
if_pc_o  out  32  PC of presented instruction, to IF/ID
if_inst_o  out  32  presented instruction, to IF/ID
if_valid_o  out  1  if_pc_o/if_inst_o hold a valid fetched instruction

Behaviour:
- Reset values: pc_q=RESET_PC, inst_q=0, drop_q=0, state=IDLE; outputs imem_req_o=0, imem_addr_o=RESET_PC, if_pc_o=RESET_PC, if_inst_o=0, if_valid_o=0.
- Outputs come straight from registers: imem_req_o=(state==REQ), imem_addr_o=pc_q, if_pc_o=pc_q, if_inst_o=inst_q, if_valid_o=(state==VALID).
- At most one outstanding memory read.
- FSM states: IDLE, REQ, WAIT, VALID.
- IDLE: one cycle after reset release, unconditionally -> REQ.
- REQ:
  - gnt and no flush -> WAIT.
  - gnt and flush -> pc_q<=target, drop_q<=1, -> WAIT.
  - no gnt and flush -> pc_q<=target, stay REQ.
  - no gnt and no flush -> stay REQ; imem_addr_o must stay stable while req is high.
- WAIT:
  - rvalid with drop_q=1 or flush_i=1 -> discard data, drop_q<=0, pc_q<=target if flush_i, -> REQ.
  - rvalid otherwise -> inst_q<=rdata, -> VALID.
  - flush_i without rvalid -> pc_q<=target, drop_q<=1, stay WAIT.
- VALID:
  - flush_i -> pc_q<=target, -> REQ. Flush has priority over stall.
  - else stall_i -> stay; pc/inst/valid held stable.
  - else (consumed) -> pc_q<=pc_q+PC_STEP, -> REQ.
- Latency: gnt in the first REQ cycle and rvalid the next cycle give if_valid_o 2 cycles after the req cycle. Peak throughput is 1 instruction per 3 cycles; overlap is out of scope.
- PC arithmetic is 32-bit modulo: 0xFFFF_FFFC+4 wraps to 0x0000_0000.
- imem_rvalid_i outside WAIT and imem_gnt_i outside REQ are ignored.
- Reset mid-operation: asynchronous return to reset values. A pending memory response after reset arrives outside WAIT and is ignored.

Decomposition:
- Shared stage1 package: FSM state encoding (2-bit), PC width constant 32, NOP instruction constant 32'h0000_0000.
- Single module; no sub-module needed. The PC register and next-PC mux stay inline.

Test Plan:
- Reset release, memory gnt immediate, rvalid 1 cycle later with rdata=0x2408_0001, no stall -> imem_addr 0x0, if_valid pulses with pc=0x0, inst=0x24080001; next req addr=0x4.
- stall_i held 5 cycles during VALID -> if_valid_o, if_pc_o, if_inst_o constant for all 5 cycles; no new req; release -> req addr=pc+4.
- gnt withheld 4 cycles in REQ -> imem_req_o and imem_addr_o stable; inst presented only after gnt then rvalid.
- flush_i with target=0x0000_0103 during WAIT, rvalid 3 cycles later -> stale data discarded, if_valid_o stays 0, next req addr=0x0000_0100.
- flush_i and stall_i together in VALID with target=0x40 -> valid drops next cycle, req addr=0x40.
- RESET_PC=0xFFFF_FFFC, one consumed fetch -> next req addr=0x0000_0000.
